mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer_if.sv | 31 +++
 rtl/mdu_sequencer.sv | 131 +++++++++++++
 tb/tb_mdu_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - request/result bundle between a CPU pipeline and the mult/div sequencer
// Signals:
//   Req    exception/interrupt request, blocks acceptance in its cycle
//   Start  launch mult/multu/div/divu selected by MDUOp
//   MDUOp  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
//   D1     rs operand (multiplicand, dividend, mthi/mtlo data)
//   D2     rt operand (multiplier, divisor)
//   Busy   operation in flight
//   Done   one-cycle pulse when new HI/LO become visible
//   HI/LO  architectural HI/LO registers
interface mdu_sequencer_if;
  logic        Req;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Req, Start, MDUOp, D1, D2,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Req, Start, MDUOp, D1, D2,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - 32-cycle radix-2 multiply/divide unit with architectural HI/LO
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset
//   bus    mdu_sequencer_if.slave: Req/Start/MDUOp/D1/D2 in, Busy/Done/HI/LO out
// Operations work on magnitudes; signs are re-applied in the single FIX cycle.
module mdu_sequencer (
  input logic            clk,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_lo;    // product sign for multiply, quotient sign for divide
  logic        neg_hi;    // remainder sign (follows the dividend)
  logic        div_zero;
  logic [31:0] opb;       // multiplicand or divisor magnitude
  logic [63:0] acc;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;

  logic        op_valid;
  logic        op_signed;
  logic        accept;
  logic [31:0] mag1;
  logic [31:0] mag2;

  assign op_valid  = (bus.MDUOp >= 4'd1) && (bus.MDUOp <= 4'd4);
  assign op_signed = (bus.MDUOp == 4'd1) || (bus.MDUOp == 4'd3);
  assign accept    = (state == IDLE) && bus.Start && !bus.Req && op_valid;
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  assign mag1      = (op_signed && bus.D1[31]) ? -bus.D1 : bus.D1;
  assign mag2      = (op_signed && bus.D2[31]) ? -bus.D2 : bus.D2;

  // Multiply step: conditionally add multiplicand to the upper half, then shift
  // the 65-bit {carry, acc} right by one.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // Divide step: shifted remainder is 33 bits wide; when it is >= divisor the
  // true difference is below 2^32, so the low 32 bits of the subtraction suffice.
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  assign div_ge   = acc[63:31] >= {1'b0, opb};
  assign div_sub  = acc[62:31] - opb;
  assign div_next = div_ge ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_hi ? -acc[63:32] : acc[63:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      opb      <= 32'd0;
      acc      <= 64'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // Register moves are independent of Start.
          if (!bus.Req) begin
            if (bus.MDUOp == 4'd5) hi_r <= bus.D1;
            if (bus.MDUOp == 4'd6) lo_r <= bus.D1;
          end
          if (accept) begin
            state    <= RUN;
            cnt      <= 6'd0;
            is_div   <= (bus.MDUOp >= 4'd3);
            neg_lo   <= op_signed && (bus.D1[31] ^ bus.D2[31]);
            neg_hi   <= op_signed && bus.D1[31];
            div_zero <= (bus.D2 == 32'd0);
            if (bus.MDUOp >= 4'd3) begin
              opb <= mag2;
              acc <= {32'd0, mag1};
            end else begin
              opb <= mag1;
              acc <= {32'd0, mag2};
            end
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          state  <= IDLE;
          done_r <= 1'b1;
          if (!is_div) begin
            hi_r <= prod_fix[63:32];
            lo_r <= prod_fix[31:0];
          end else if (!div_zero) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = (state != IDLE);
  assign bus.Done = done_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer against a cycle-count arithmetic model
module tb_mdu_sequencer;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  mdu_sequencer_if bus ();

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation from plain integer arithmetic.
  function automatic void predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic wr, output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    wr = 1'b1;
    h  = 32'd0;
    l  = 32'd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      4'd3, 4'd4: begin
        if (op == 4'd4) begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        if (b == 32'd0) wr = 1'b0;
        else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Model: an accepted op keeps Busy for 33 cycles, then results land with Done.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0;
  int          m_left = 0;

  always @(posedge clk or posedge reset) begin
    logic w;
    logic [31:0] ph, pl;
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_wr <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (m_wr) begin m_hi <= m_phi; m_lo <= m_plo; end
        end
      end else if (!bus.Req) begin
        if (bus.Start && bus.MDUOp >= 4'd1 && bus.MDUOp <= 4'd4) begin
          predict(bus.MDUOp, bus.D1, bus.D2, w, ph, pl);
          m_wr <= w; m_phi <= ph; m_plo <= pl;
          m_left <= 33;
          m_busy <= 1'b1;
        end
        if (bus.MDUOp == 4'd5) m_hi <= bus.D1;
        if (bus.MDUOp == 4'd6) m_lo <= bus.D1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check32("model_busy", {31'd0, bus.Busy}, {31'd0, m_busy});
      check32("model_done", {31'd0, bus.Done}, {31'd0, m_done});
      check32("model_hi", bus.HI, m_hi);
      check32("model_lo", bus.LO, m_lo);
    end
  end

  task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    bus.Start = st; bus.MDUOp = op; bus.D1 = a; bus.D2 = b; bus.Req = rq;
    @(posedge clk);
    #1;
    bus.Start = 1'b0; bus.MDUOp = 4'd0; bus.D1 = 32'd0; bus.D2 = 32'd0; bus.Req = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.Done && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!bus.Done) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no Done after %0d cycles, expected Done", cycles);
    end
  endtask

  int c;

  initial begin
    bus.Start = 1'b0; bus.MDUOp = 4'd0; bus.D1 = 32'd0; bus.D2 = 32'd0; bus.Req = 1'b0;
    #1 reset = 1'b1;
    #1;
    check32("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check32("reset_done", {31'd0, bus.Done}, 32'd0);
    check32("reset_hi", bus.HI, 32'd0);
    check32("reset_lo", bus.LO, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    step(1);

    // mult -1 * 2 with exact timing
    drive(1'b1, 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    check32("mult_busy_c1", {31'd0, bus.Busy}, 32'd1);
    step(32);
    check32("mult_busy_c33", {31'd0, bus.Busy}, 32'd1);
    check32("mult_done_c33", {31'd0, bus.Done}, 32'd0);
    step(1);
    check32("mult_busy_c34", {31'd0, bus.Busy}, 32'd0);
    check32("mult_done_c34", {31'd0, bus.Done}, 32'd1);
    check32("mult_hi", bus.HI, 32'hFFFFFFFF);
    check32("mult_lo", bus.LO, 32'hFFFFFFFE);

    drive(1'b1, 4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_done(c);
    check32("multu_hi", bus.HI, 32'h00000001);
    check32("multu_lo", bus.LO, 32'hFFFFFFFE);

    drive(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done(c);
    check32("div_m7_2_lo", bus.LO, 32'hFFFFFFFD);
    check32("div_m7_2_hi", bus.HI, 32'hFFFFFFFF);

    drive(1'b1, 4'd3, 32'd7, 32'hFFFFFFFE, 1'b0);
    wait_done(c);
    check32("div_7_m2_lo", bus.LO, 32'hFFFFFFFD);
    check32("div_7_m2_hi", bus.HI, 32'h00000001);

    drive(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done(c);
    check32("div_ovf_lo", bus.LO, 32'h80000000);
    check32("div_ovf_hi", bus.HI, 32'h00000000);

    // mthi without Start, then divide by zero leaves HI/LO alone
    drive(1'b0, 4'd5, 32'h1234, 32'd0, 1'b0);
    check32("mthi_hi", bus.HI, 32'h00001234);
    drive(1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
    wait_done(c);
    check32("divz_cycles", c, 32'd33);
    check32("divz_hi", bus.HI, 32'h00001234);
    check32("divz_lo", bus.LO, 32'h80000000);

    // Req suppresses acceptance, retry next cycle works
    bus.Start = 1'b1; bus.MDUOp = 4'd1; bus.D1 = 32'd3; bus.D2 = 32'd4; bus.Req = 1'b1;
    step(1);
    check32("req_busy", {31'd0, bus.Busy}, 32'd0);
    check32("req_hi", bus.HI, 32'h00001234);
    bus.Req = 1'b0;
    step(1);
    bus.Start = 1'b0; bus.MDUOp = 4'd0;
    check32("retry_busy", {31'd0, bus.Busy}, 32'd1);
    wait_done(c);
    check32("retry_lo", bus.LO, 32'd12);
    check32("retry_hi", bus.HI, 32'd0);

    // back-to-back with an ignored mtlo in flight
    drive(1'b1, 4'd2, 32'h00010000, 32'h00010000, 1'b0);
    wait_done(c);
    check32("b2b_a_hi", bus.HI, 32'd1);
    check32("b2b_a_lo", bus.LO, 32'd0);
    drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
    check32("b2b_accept", {31'd0, bus.Busy}, 32'd1);
    drive(1'b0, 4'd6, 32'hDEAD, 32'd0, 1'b0);
    wait_done(c);
    check32("b2b_cycles", c, 32'd32);
    check32("b2b_b_lo", bus.LO, 32'd30);
    check32("b2b_b_hi", bus.HI, 32'd0);

    drive(1'b1, 4'd9, 32'd1, 32'd1, 1'b0);
    check32("badop_busy", {31'd0, bus.Busy}, 32'd0);
    drive(1'b0, 4'd6, 32'hBEEF, 32'd0, 1'b1);
    check32("mtlo_req_lo", bus.LO, 32'd30);

    // reset mid-operation
    drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
    step(9);
    reset = 1'b1;
    #1;
    check32("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
    check32("rst_mid_hi", bus.HI, 32'd0);
    check32("rst_mid_lo", bus.LO, 32'd0);
    step(2);
    reset = 1'b0;
    step(3);
    drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
    wait_done(c);
    check32("post_rst_lo", bus.LO, 32'd14);
    check32("post_rst_hi", bus.HI, 32'd2);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
